// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: FSM state encoding and frame
// constants. Imported by prog_loader and by anything that decodes its state.
// -----------------------------------------------------------------------------
package loader_pkg;

    // FSM state encoding (kept as plain vectors for legacy tool compatibility).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEN   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    // A frame is: FRAME_HDR_WORDS length word(s), L data words, one checksum.
    localparam int          FRAME_HDR_WORDS = 1;

    // Seed for the XOR checksum accumulator.
    localparam logic [15:0] CHK_INIT = 16'h0000;

endpackage : loader_pkg

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a program frame (length word, L data words, XOR checksum word) from
// the byte-to-word assembler, writes the data words into instruction memory at
// consecutive addresses starting from 0, and releases the CPU from reset only
// when the checksum matches.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   ce         : clock enable; when low all registers hold
//   start      : single-cycle request to begin a load (ignored while busy)
//   word_dv    : assembled-word valid strobe
//   word       : assembled 16-bit word
//   b2w_ce     : enable for the byte-to-word assembler (ce while busy)
//   mem_we     : instruction-memory write strobe
//   mem_addr   : instruction-memory write address
//   mem_wdata  : instruction-memory write data
//   cpu_rst    : hold CPU in reset
//   busy       : load in progress
//   done       : one-cycle pulse on a successful load
//   err        : sticky error (bad length or checksum mismatch)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic              word_dv,
    input  logic [15:0]       word,
    output logic              b2w_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import loader_pkg::*;

    // One extra bit so the data counter can reach MAX_LEN (== 2**ADDR_W)
    // without wrapping inside a frame.
    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN_V = 17'(MAX_LEN);

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  idx_q,       idx_d;
    logic [CNT_W-1:0]  len_q,       len_d;
    logic [15:0]       acc_q,       acc_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic              cpu_rst_q,   cpu_rst_d;

    logic              len_too_big;
    logic              last_data;

    assign len_too_big = {1'b0, word} > MAX_LEN_V;
    assign last_data   = (idx_q + CNT_W'(1)) == len_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cpu_rst_d   = cpu_rst_q;

        case (state_q)
            ST_IDLE: begin
                // word_dv is ignored here, including when it coincides with start.
                if (start) begin
                    state_d   = ST_LEN;
                    idx_d     = '0;
                    acc_d     = CHK_INIT;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                end
            end

            ST_LEN: begin
                if (word_dv) begin
                    if (len_too_big) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (word == 16'h0000) begin
                        state_d = ST_CHECK;
                    end else begin
                        len_d   = CNT_W'(word);
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (word_dv) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    acc_d       = acc_q ^ word;
                    idx_d       = idx_q + CNT_W'(1);
                    if (last_data) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (word_dv) begin
                    state_d = ST_IDLE;
                    if (word == acc_q) begin
                        done_d    = 1'b1;
                        err_d     = 1'b0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d     = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of the others, independent of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            acc_q       <= CHK_INIT;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_q   <= 1'b1;
        end else if (ce) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    // The strobes hold across ce=0 cycles and are masked there, so a pending
    // write or done is presented exactly once, in the next enabled cycle.
    assign mem_we    = mem_we_q & ce;
    assign done      = done_q & ce;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = (state_q != ST_IDLE);
    assign b2w_ce    = busy & ce;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed self-checking bench for prog_loader. Inputs change 1 ns after the
// rising edge; a negedge monitor logs memory writes and done pulses.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start;
    logic        word_dv;
    logic [15:0] word;
    logic        b2w_ce;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          ce_viol  = 0;
    logic [7:0]  wr_addr [16];
    logic [15:0] wr_data [16];

    prog_loader #(.ADDR_W(8), .MAX_LEN(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .start     (start),
        .word_dv   (word_dv),
        .word      (word),
        .b2w_ce    (b2w_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: one sample per cycle, so a one-cycle strobe counts once.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
        end
        if (done) done_cnt++;
        if (mem_we && !ce) ce_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt   = 0;
        done_cnt = 0;
        ce_viol  = 0;
    endtask

    task automatic send_word(input logic [15:0] w);
        word    = w;
        word_dv = 1'b1;
        step();
        word_dv = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One enabled cycle presenting the word, then one disabled cycle with
    // word_dv still high (must be ignored).
    task automatic send_word_tog(input logic [15:0] w);
        ce      = 1'b1;
        word    = w;
        word_dv = 1'b1;
        step();
        ce      = 1'b0;
        step();
        word_dv = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_we"},    32'(mem_we),    32'h0);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, ".done"},      32'(done),      32'h0);
        check({tag, ".err"},       32'(err),       32'h0);
        check({tag, ".busy"},      32'(busy),      32'h0);
        check({tag, ".b2w_ce"},    32'(b2w_ce),    32'h0);
        check({tag, ".cpu_rst"},   32'(cpu_rst),   32'h1);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b0; word_dv = 1'b0; word = 16'h0;

        // Reset values
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // L=3 good frame; start while busy must be ignored
        clear_log();
        pulse_start();
        check("t1.busy", 32'(busy), 32'h1);
        check("t1.b2w_ce", 32'(b2w_ce), 32'h1);
        check("t1.cpu_rst", 32'(cpu_rst), 32'h1);
        send_word(16'd3);
        send_word(16'h1234);
        check("t1.we_lat", 32'(mem_we), 32'h1);
        check("t1.addr_lat", 32'(mem_addr), 32'h0);
        check("t1.data_lat", 32'(mem_wdata), 32'h1234);
        pulse_start();
        check("t1.busy_start", 32'(busy), 32'h1);
        send_word(16'hABCD);
        send_word(16'h0F0F);
        send_word(16'hB6F6);
        check("t1.done_now", 32'(done), 32'h1);
        check("t1.cpu_rst_done", 32'(cpu_rst), 32'h0);
        step();
        check("t1.done_gone", 32'(done), 32'h0);
        step();
        check("t1.wr_cnt", 32'(wr_cnt), 32'd3);
        check("t1.a0", 32'(wr_addr[0]), 32'h0);
        check("t1.d0", 32'(wr_data[0]), 32'h1234);
        check("t1.a1", 32'(wr_addr[1]), 32'h1);
        check("t1.d1", 32'(wr_data[1]), 32'hABCD);
        check("t1.a2", 32'(wr_addr[2]), 32'h2);
        check("t1.d2", 32'(wr_data[2]), 32'h0F0F);
        check("t1.done_cnt", 32'(done_cnt), 32'd1);
        check("t1.err", 32'(err), 32'h0);
        check("t1.busy_end", 32'(busy), 32'h0);

        // Same frame, bad checksum
        clear_log();
        pulse_start();
        check("t2.cpu_rst_rearm", 32'(cpu_rst), 32'h1);
        send_word(16'd3);
        send_word(16'h1234);
        send_word(16'hABCD);
        send_word(16'h0F0F);
        send_word(16'h0000);
        step();
        step();
        check("t2.wr_cnt", 32'(wr_cnt), 32'd3);
        check("t2.d2", 32'(wr_data[2]), 32'h0F0F);
        check("t2.err", 32'(err), 32'h1);
        check("t2.cpu_rst", 32'(cpu_rst), 32'h1);
        check("t2.done_cnt", 32'(done_cnt), 32'd0);
        check("t2.busy", 32'(busy), 32'h0);

        // Start clears err; then over-long length aborts
        clear_log();
        pulse_start();
        check("t3.err_clr", 32'(err), 32'h0);
        check("t3.cpu_rst", 32'(cpu_rst), 32'h1);
        send_word(16'h0101);
        check("t3.err", 32'(err), 32'h1);
        check("t3.busy", 32'(busy), 32'h0);
        send_word(16'h5555);   // ignored in IDLE
        step();
        check("t3.wr_cnt", 32'(wr_cnt), 32'd0);
        check("t3.idle_dv", 32'(busy), 32'h0);

        // L=0 frame, start coinciding with word_dv
        clear_log();
        start   = 1'b1;
        word    = 16'h0007;
        word_dv = 1'b1;
        step();
        start   = 1'b0;
        word_dv = 1'b0;
        check("t4.busy", 32'(busy), 32'h1);
        send_word(16'd0);
        check("t4.in_check", 32'(busy), 32'h1);
        send_word(16'h0000);
        step();
        check("t4.wr_cnt", 32'(wr_cnt), 32'd0);
        check("t4.done_cnt", 32'(done_cnt), 32'd1);
        check("t4.err", 32'(err), 32'h0);
        check("t4.cpu_rst", 32'(cpu_rst), 32'h0);

        // L=2 with ce toggling every cycle
        clear_log();
        ce = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        ce = 1'b0;
        step();
        check("t5.b2w_ce_off", 32'(b2w_ce), 32'h0);
        send_word_tog(16'd2);
        send_word_tog(16'h5A5A);
        send_word_tog(16'h1111);
        send_word_tog(16'h4B4B);
        ce = 1'b1;
        step();
        step();
        check("t5.wr_cnt", 32'(wr_cnt), 32'd2);
        check("t5.a0", 32'(wr_addr[0]), 32'h0);
        check("t5.d0", 32'(wr_data[0]), 32'h5A5A);
        check("t5.a1", 32'(wr_addr[1]), 32'h1);
        check("t5.d1", 32'(wr_data[1]), 32'h1111);
        check("t5.done_cnt", 32'(done_cnt), 32'd1);
        check("t5.ce_viol", 32'(ce_viol), 32'd0);
        check("t5.err", 32'(err), 32'h0);
        check("t5.cpu_rst", 32'(cpu_rst), 32'h0);

        // Reset mid-frame, then a fresh L=1 frame
        pulse_start();
        send_word(16'd4);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        rst = 1'b1;
        step();
        check_reset_outputs("t6");
        rst = 1'b0;
        clear_log();
        pulse_start();
        send_word(16'd1);
        send_word(16'h7777);
        send_word(16'h7777);
        step();
        check("t6.wr_cnt", 32'(wr_cnt), 32'd1);
        check("t6.a0", 32'(wr_addr[0]), 32'h0);
        check("t6.d0", 32'(wr_data[0]), 32'h7777);
        check("t6.done_cnt", 32'(done_cnt), 32'd1);
        check("t6.cpu_rst", 32'(cpu_rst), 32'h0);
        check("t6.err", 32'(err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_prog_loader
